// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the I-format datapath: FETCH/DECODE/EXEC/MEM/WB with DM wait states.
// Per instruction, FETCH to FETCH: R/addi 4, sw 4+W, lw 5+W cycles; DM stalls via mem_ready.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [RET_W-1:0] retired
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    logic [5:0]        r_op_q;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [RET_W-1:0]  r_retired;
    logic              r_err_illegal;
    logic              r_err_timeout;

    state_t            w_state_nxt;
    logic [5:0]        w_op_nxt;
    logic [WC_W-1:0]   w_wait_nxt;
    logic              w_retire;
    logic              w_set_illegal;
    logic              w_set_timeout;
    logic              w_op_legal;
    logic              w_is_mem_op;

    assign w_op_legal  = (opcode == OP_R) || (opcode == OP_ADDI) ||
                         (opcode == OP_LW) || (opcode == OP_SW);
    assign w_is_mem_op = (r_op_q == OP_LW) || (r_op_q == OP_SW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_op_q        <= 6'h00;
            r_wait_cnt    <= '0;
            r_retired     <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op_q     <= w_op_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_retire)      r_retired     <= r_retired + RET_W'(1);
            if (w_set_illegal) r_err_illegal <= 1'b1;
            if (w_set_timeout) r_err_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op_q;
        w_wait_nxt    = r_wait_cnt;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (run) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_op_nxt = opcode;
                if (w_op_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt   = S_HALT;
                    w_set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                w_state_nxt = w_is_mem_op ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_wait_nxt = '0;
                    if (r_op_q == OP_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST)) begin
                    w_wait_nxt    = '0;
                    w_state_nxt   = S_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + WC_W'(1);
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // ALU selects stay valid through MEM/WB so the address and write-back data remain stable.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                pc_write = run & ~rst;
                ir_write = run & ~rst;
            end
            S_EXEC: begin
                alu_src = (r_op_q != OP_R);
                alu_op  = (r_op_q == OP_R) ? 2'b10 : 2'b00;
            end
            S_MEM: begin
                mem_read  = (r_op_q == OP_LW);
                mem_write = (r_op_q == OP_SW);
                alu_src   = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (r_op_q == OP_R);
                mem_to_reg = (r_op_q == OP_LW);
                alu_src    = (r_op_q != OP_R);
                alu_op     = (r_op_q == OP_R) ? 2'b10 : 2'b00;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = r_state;
    assign retired     = r_retired;
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized instruction streams checked cycle by cycle against a phase-table model.
module tb_multicycle_ctrl;
    localparam int TO = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, run, mem_ready;
    logic [5:0]    opcode;
    logic          pc_write, ir_write, reg_write, mem_read, mem_write;
    logic          mem_to_reg, reg_dst, alu_src, halted, err_illegal, err_timeout;
    logic [1:0]    alu_op;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .state(state),
        .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
        .retired(retired)
    );

    always #5 clk = ~clk;

    wire [13:0] w_obs = {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
                         reg_dst, alu_src, alu_op, halted, state};

    int n_asrt = 0;
    int n_fail = 0;
    int exp_ret = 0;
    int ncyc = 0;
    logic exp_ill = 1'b0;
    logic exp_to  = 1'b0;
    logic [5:0] ops [4] = '{6'h00, 6'h08, 6'h23, 6'h2B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for one phase of an instruction, straight from the control table.
    function automatic logic [13:0] exp_vec(input int ph, input logic [5:0] op, input logic r);
        logic pc, ir, rw, mr, mw, m2r, rd, as, hl;
        logic [1:0] ao;
        {pc, ir, rw, mr, mw, m2r, rd, as, hl} = '0;
        ao = 2'b00;
        case (ph)
            0: begin pc = r; ir = r; end
            2: begin as = (op != 6'h00); ao = (op == 6'h00) ? 2'b10 : 2'b00; end
            3: begin mr = (op == 6'h23); mw = (op == 6'h2B); as = 1'b1; end
            4: begin
                rw = 1'b1; rd = (op == 6'h00); m2r = (op == 6'h23);
                as = (op != 6'h00); ao = (op == 6'h00) ? 2'b10 : 2'b00;
            end
            5: hl = 1'b1;
            default: ;
        endcase
        return {pc, ir, rw, mr, mw, m2r, rd, as, ao, hl, 3'(ph)};
    endfunction

    // One clock: inputs already applied after the previous edge; check at negedge, advance.
    task automatic step(input string tag, input int ph, input logic [5:0] op);
        @(negedge clk);
        chk({tag, "_outs"}, 32'(w_obs), 32'(exp_vec(ph, op, run)));
        chk({tag, "_ret"}, 32'(retired), 32'(exp_ret % (1 << RW)));
        chk({tag, "_err"}, {30'd0, err_illegal, err_timeout}, {30'd0, exp_ill, exp_to});
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        run = 1'b1;
        #1;
        chk("reset_outs", 32'(w_obs), 32'd0);
        chk("reset_ret", 32'(retired), 32'd0);
        chk("reset_err", {30'd0, err_illegal, err_timeout}, 32'd0);
        run = 1'b0;
        exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // w = number of mem_ready=0 cycles before ready; w >= TO means the access never completes.
    task automatic do_instr(input logic [5:0] op, input int w, input int idle);
        int start;
        int lat;
        run = 1'b0;
        opcode = 6'($urandom);
        mem_ready = 1'($urandom);
        for (int i = 0; i < idle; i++) step("idle", 0, op);
        run = 1'b1; opcode = op; mem_ready = 1'b0;
        start = ncyc;
        step("fetch", 0, op);
        run = 1'b0;
        step("decode", 1, op);
        if (!(op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B)) begin
            exp_ill = 1'b1;
            step("ill_halt", 5, op);
            return;
        end
        opcode = 6'($urandom);
        step("exec", 2, op);
        if (op == 6'h23 || op == 6'h2B) begin
            for (int k = 0; k < TO; k++) begin
                mem_ready = (k == w);
                step("mem", 3, op);
                mem_ready = 1'b0;
                if (k == w) break;
                if (k == TO - 1) begin
                    exp_to = 1'b1;
                    step("to_halt", 5, op);
                    return;
                end
            end
        end
        if (op == 6'h2B) begin
            exp_ret++;
        end else begin
            step("wb", 4, op);
            exp_ret++;
        end
        lat = (op == 6'h2B) ? 4 + w : (op == 6'h23) ? 5 + w : 4;
        chk("latency", 32'(ncyc - start), 32'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
        #12;
        do_reset();

        do_instr(6'h00, 0, 0);
        do_instr(6'h23, 3, 1);
        do_instr(6'h2B, 0, 0);
        do_instr(6'h08, 0, 2);

        for (int i = 0; i < 24; i++)
            do_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 4), $urandom_range(0, 2));

        // Asynchronous reset in the middle of a stalled store.
        run = 1'b1; opcode = 6'h2B; mem_ready = 1'b0;
        step("r6_fetch", 0, 6'h2B);
        run = 1'b0;
        step("r6_decode", 1, 6'h2B);
        step("r6_exec", 2, 6'h2B);
        step("r6_mem", 3, 6'h2B);
        #3;
        chk("r6_mw_before", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("r6_mw_drop", 32'(mem_write), 32'd0);
        chk("r6_state", 32'(state), 32'd0);
        chk("r6_ret", 32'(retired), 32'd0);
        exp_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_instr(6'h00, 0, 0);

        do_instr(6'h3F, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom); opcode = 6'($urandom); mem_ready = 1'($urandom);
            step("halt_hold", 5, 6'h00);
        end
        do_reset();

        do_instr(6'h23, 1000, 0);
        run = 1'b1;
        step("to_hold", 5, 6'h00);
        do_reset();
        do_instr(6'h08, 0, 0);
        do_instr(6'h2B, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
